// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/sequence controller for the program counter.
//
// The PC register lives outside this block. Every cycle this block drives the
// register's next-value input: normally the current value (hold), and in the
// single retire cycle of an instruction the PC+4, branch target, trap vector
// or saved EPC. It also runs the instruction-memory req/ack handshake, issues
// one instruction at a time to the core, records EPC/cause on traps and
// raises a sticky fault when memory fails to answer in time.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   pc_cur / pc_next           PC register output / PC register next value
//   imem_req, imem_addr        fetch request (held until ack), fetch address
//   imem_ack, imem_rdata       fetch completion and fetched word
//   instr_valid, instr,        issued instruction and its PC, stable until
//   instr_pc                   the core retires it
//   retire                     core finished the issued instruction
//   branch_taken, branch_target, trap_req, trap_cause, mret
//                              retire qualifiers (only looked at on retire)
//   halt                       level request to stop at an instruction boundary
//   epc, mcause                saved exception PC and cause
//   halted, fetch_fault        HALT state indicator, sticky fetch timeout flag
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  input  logic        mret,
  input  logic        halt,
  output logic [31:0] epc,
  output logic [3:0]  mcause,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [31:0]     instr_next, instr_pc_next, epc_next, pc_sel;
  logic [3:0]      mcause_next;
  logic            fault_next;

  // The fetch address is always the live PC; the request is a decode of the
  // registered state, forced low while reset is asserted so that a reset in
  // the middle of a handshake withdraws the request immediately.
  assign imem_addr = pc_cur;
  assign imem_req  = (state == S_FETCH) && !reset;

  // During reset the PC register must be steered to the reset vector.
  assign pc_next = reset ? RESET_VECTOR : pc_sel;

  // Next-state, next-PC selection and next values of the architectural regs.
  always_comb begin
    state_next    = state;
    timer_next    = timer;
    instr_next    = instr;
    instr_pc_next = instr_pc;
    epc_next      = epc;
    mcause_next   = mcause;
    fault_next    = fetch_fault;
    pc_sel        = pc_cur;

    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          instr_next    = imem_rdata;
          instr_pc_next = pc_cur;
          timer_next    = '0;
          state_next    = S_ISSUE;
        end else if (timer == TIMER_LAST) begin
          // TIMEOUT request cycles have gone unanswered.
          timer_next  = '0;
          fault_next  = 1'b1;
          mcause_next = 4'hF;
          epc_next    = pc_cur;
          state_next  = S_HALT;
        end else begin
          timer_next = timer + TIMER_ONE;
        end
      end

      S_ISSUE: begin
        if (retire) begin
          if (trap_req) begin
            pc_sel      = TRAP_VECTOR;
            epc_next    = instr_pc;
            mcause_next = trap_cause;
          end else if (mret) begin
            pc_sel = epc;
          end else if (branch_taken) begin
            if (branch_target[1:0] != 2'b00) begin
              // A misaligned redirect is converted into a trap with cause 0.
              pc_sel      = TRAP_VECTOR;
              epc_next    = instr_pc;
              mcause_next = 4'h0;
            end else begin
              pc_sel = branch_target;
            end
          end else begin
            pc_sel = pc_cur + 32'd4;
          end
          state_next = halt ? S_HALT : S_FETCH;
        end else begin
          state_next = S_ISSUE;
        end
      end

      S_HALT: begin
        // A fault halt is only left through reset.
        if (!halt && !fetch_fault) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_HALT;
        end
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      timer       <= '0;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      instr_valid <= 1'b0;
      epc         <= 32'h0000_0000;
      mcause      <= 4'h0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= (state_next == S_ISSUE);
      epc         <= epc_next;
      mcause      <= mcause_next;
      halted      <= (state_next == S_HALT);
      fetch_fault <= fault_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The bench provides the PC register
// and an instruction memory whose contents are a fixed function of address.
// Expected fetch addresses are queued when a retire is driven and popped when
// the DUT raises the next fetch request.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        retire = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        trap_req = 1'b0;
  logic [3:0]  trap_cause = 4'h0;
  logic        mret = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] epc;
  logic [3:0]  mcause;
  logic        halted;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q[$];

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .TRAP_VECTOR (TV),
    .TIMEOUT     (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_cur       (pc_reg),
    .pc_next      (pc_next),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .retire       (retire),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .trap_req     (trap_req),
    .trap_cause   (trap_cause),
    .mret         (mret),
    .halt         (halt),
    .epc          (epc),
    .mcause       (mcause),
    .halted       (halted),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer steers.
  always @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= RV;
    else       pc_reg <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait for a request, check its address against the scoreboard, ack after
  // lat idle cycles and check the issued instruction.
  task automatic fetch_one(input int lat);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL req_wait: imem_req=%0b required 1", imem_req);
      return;
    end
    exp = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
    vectors++;
    if (imem_addr !== exp) begin
      miscompares++;
      $display("FAIL fetch_addr: got %h required %h", imem_addr, exp);
    end
    vectors++;
    if (pc_next !== exp) begin
      miscompares++;
      $display("FAIL fetch_hold: pc_next %h required %h", pc_next, exp);
    end
    repeat (lat) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL req_held: imem_req=%0b required 1", imem_req);
    end
    imem_ack = 1'b1;
    imem_rdata = mem_word(exp);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_word(exp) || instr_pc !== exp || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL issue: valid=%0b instr=%h pc=%h req=%0b required 1 %h %h 0",
               instr_valid, instr, instr_pc, imem_req, mem_word(exp), exp);
    end
  endtask

  // Retire the issued instruction with the given qualifiers; halt stays at hl.
  task automatic retire_one(input logic br, input logic [31:0] tgt, input logic tr,
                            input logic [3:0] cause, input logic mr, input logic hl,
                            input logic [31:0] exp_next);
    retire = 1'b1;
    branch_taken = br;
    branch_target = tgt;
    trap_req = tr;
    trap_cause = cause;
    mret = mr;
    halt = hl;
    #1;
    vectors++;
    if (pc_next !== exp_next) begin
      miscompares++;
      $display("FAIL retire_pc: pc_next %h required %h", pc_next, exp_next);
    end
    exp_addr_q.push_back(exp_next);
    @(negedge clk);
    retire = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    trap_req = 1'b0;
    trap_cause = 4'h0;
    mret = 1'b0;
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_drop: instr_valid=%0b required 0", instr_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0 || fetch_fault !== 1'b0 ||
        epc !== 32'h0 || mcause !== 4'h0 || instr !== 32'h0 || instr_pc !== 32'h0 || pc_next !== RV) begin
      miscompares++;
      $display("FAIL reset_state: req=%0b v=%0b h=%0b ff=%0b epc=%h mc=%h i=%h ipc=%h pcn=%h required all zero, pcn=%h",
               imem_req, instr_valid, halted, fetch_fault, epc, mcause, instr, instr_pc, pc_next, RV);
    end
    reset = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(RV);
  endtask

  task automatic test_sequential();
    fetch_one(1);
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h0)) begin
      miscompares++;
      $display("FAIL issue_stable: valid=%0b instr=%h required 1 %h", instr_valid, instr, mem_word(32'h0));
    end
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h4);
    fetch_one(0);
    @(negedge clk);
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h8);
    fetch_one(1);
  endtask

  task automatic test_branch();
    @(negedge clk);
    retire_one(1'b1, 32'h40, 1'b0, 4'h0, 1'b0, 1'b0, 32'h40);
    fetch_one(1);
    retire_one(1'b1, 32'h8, 1'b0, 4'h0, 1'b0, 1'b0, 32'h8);
    fetch_one(0);
    retire_one(1'b1, 32'h42, 1'b0, 4'h0, 1'b0, 1'b0, TV);
    vectors++;
    if (epc !== 32'h8 || mcause !== 4'h0) begin
      miscompares++;
      $display("FAIL misaligned: epc=%h mcause=%h required 00000008 0", epc, mcause);
    end
    fetch_one(1);
  endtask

  task automatic test_trap_mret();
    retire_one(1'b1, 32'h44, 1'b0, 4'h0, 1'b0, 1'b0, 32'h44);
    fetch_one(1);
    retire_one(1'b0, 32'h0, 1'b1, 4'hB, 1'b0, 1'b0, TV);
    vectors++;
    if (epc !== 32'h44 || mcause !== 4'hB) begin
      miscompares++;
      $display("FAIL trap_save: epc=%h mcause=%h required 00000044 b", epc, mcause);
    end
    fetch_one(0);
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h44);
    fetch_one(1);
  endtask

  task automatic test_priority();
    retire_one(1'b1, 32'h80, 1'b1, 4'h3, 1'b1, 1'b0, TV);
    vectors++;
    if (epc !== 32'h44 || mcause !== 4'h3) begin
      miscompares++;
      $display("FAIL prio_trap: epc=%h mcause=%h required 00000044 3", epc, mcause);
    end
    fetch_one(1);
    retire_one(1'b1, 32'h80, 1'b0, 4'h0, 1'b1, 1'b0, 32'h44);
    fetch_one(0);
  endtask

  task automatic test_wrap();
    retire_one(1'b1, 32'hFFFF_FFFC, 1'b0, 4'h0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    fetch_one(1);
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
    fetch_one(1);
  endtask

  task automatic test_halt();
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h4);
    halt = 1'b1;
    fetch_one(3);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_midfetch: halted=%0b required 0", halted);
    end
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h8);
    vectors++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_enter: halted=%0b req=%0b required 1 0", halted, imem_req);
    end
    // Retire qualifiers are ignored with nothing issued.
    retire = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    repeat (2) @(negedge clk);
    vectors++;
    if (pc_next !== 32'h8 || halted !== 1'b1 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_hold: pc_next=%h halted=%0b valid=%0b required 00000008 1 0",
               pc_next, halted, instr_valid);
    end
    retire = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    halt = 1'b0;
    @(negedge clk);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_leave: halted=%0b required 0", halted);
    end
    fetch_one(1);
  endtask

  task automatic test_timeout();
    logic [31:0] exp;
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'hC);
    exp = exp_addr_q.pop_front();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      miscompares++;
      $display("FAIL tmo_req: req=%0b addr=%h required 1 %h", imem_req, imem_addr, exp);
    end
    repeat (TMO - 1) @(negedge clk);
    vectors++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_early: fault=%0b req=%0b required 0 1", fetch_fault, imem_req);
    end
    @(negedge clk);
    vectors++;
    if (fetch_fault !== 1'b1 || halted !== 1'b1 || mcause !== 4'hF || epc !== 32'hC || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_fault: ff=%0b h=%0b mc=%h epc=%h req=%0b required 1 1 f 0000000c 0",
               fetch_fault, halted, mcause, epc, imem_req);
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (fetch_fault !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_sticky: ff=%0b h=%0b req=%0b required 1 1 0", fetch_fault, halted, imem_req);
    end
  endtask

  task automatic test_reset_midfetch();
    logic [31:0] exp;
    fetch_one(0);
    retire_one(1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h4);
    exp = exp_addr_q.pop_front();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      miscompares++;
      $display("FAIL rst_req: req=%0b addr=%h required 1 %h", imem_req, imem_addr, exp);
    end
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || pc_next !== RV) begin
      miscompares++;
      $display("FAIL rst_async: req=%0b pc_next=%h required 0 %h", imem_req, pc_next, RV);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_addr_q.push_back(RV);
    fetch_one(1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_trap_mret();
    test_priority();
    test_wrap();
    test_halt();
    test_timeout();
    test_reset();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
